// File: rtl/nic_vc_allocator_if.sv
// Purpose    : bundles the request, credit and grant signals between the NIC out-buffers and the VC allocator.
// Latency    : none; this is wiring only.
// Backpressure: none of its own. Requesters hold req_i high until they see grant_o.
// Ports: master drives the requests, busy state, credits and flit events, and observes the grants.
//        slave is the allocator side.
interface nic_vc_allocator_if #(
    parameter int N_OF_VN        = 2,
    parameter int N_OF_VC        = 3,
    parameter int N_REQ          = 4,
    parameter int N_BITS_POINTER = 5,
    parameter int N_BITS_VN      = 1,
    parameter int N_BITS_VC      = 3
);
    localparam int N_TOT_OF_VC = N_OF_VN * N_OF_VC;

    logic [N_REQ-1:0]                      req_i;
    logic [N_REQ*N_BITS_VN-1:0]            req_vn_i;
    logic [N_TOT_OF_VC-1:0]                fifo_pointer_state_i;
    logic [N_TOT_OF_VC-1:0]                credit_signal_i;
    logic                                  flit_sent_i;
    logic [N_BITS_VC-1:0]                  flit_vc_i;
    logic [N_TOT_OF_VC-1:0]                g_fifo_pointer_o;
    logic [N_TOT_OF_VC*N_BITS_POINTER-1:0] g_fifo_out_buffer_id_o;
    logic [N_REQ-1:0]                      grant_o;
    logic [N_BITS_VC-1:0]                  grant_vc_o;
    logic [N_TOT_OF_VC-1:0]                credit_avail_o;
    logic                                  err_o;

    modport master (
        output req_i, req_vn_i, fifo_pointer_state_i, credit_signal_i, flit_sent_i, flit_vc_i,
        input  g_fifo_pointer_o, g_fifo_out_buffer_id_o, grant_o, grant_vc_o, credit_avail_o, err_o
    );

    modport slave (
        input  req_i, req_vn_i, fifo_pointer_state_i, credit_signal_i, flit_sent_i, flit_vc_i,
        output g_fifo_pointer_o, g_fifo_out_buffer_id_o, grant_o, grant_vc_o, credit_avail_o, err_o
    );
endinterface

// File: rtl/nic_vc_allocator.sv
// Purpose    : allocates a free, fully credited VC of the requested VN to one of N_REQ out-buffers, round-robin.
// Latency    : the grant pulse comes 1 cycle after an eligible request is sampled in IDLE; at most one grant every 3 cycles.
// Backpressure: requesters hold req_i until granted. A VC is only granted with a full credit count and a free pointer.
// Ports: clk, rst (synchronous, active low), and bus (slave modport). bus carries:
//        requests       req_i, req_vn_i
//        VC state       fifo_pointer_state_i, credit_signal_i, flit_sent_i, flit_vc_i
//        grant outputs  grant_o, grant_vc_o, g_fifo_pointer_o, g_fifo_out_buffer_id_o
//        status         credit_avail_o, err_o
module nic_vc_allocator #(
    parameter int N_OF_VN        = 2,
    parameter int N_OF_VC        = 3,
    parameter int N_REQ          = 4,
    parameter int N_BITS_POINTER = 5,
    parameter int N_BITS_VN      = 1,
    parameter int N_BITS_VC      = 3,
    parameter int N_BITS_REQ     = 2,
    parameter int CREDIT_DEPTH   = 4,
    parameter int N_BITS_CREDIT  = 3
) (
    input  logic               clk,
    input  logic               rst,
    nic_vc_allocator_if.slave  bus
);
    localparam int N_TOT_OF_VC = N_OF_VN * N_OF_VC;
    localparam logic [N_BITS_CREDIT-1:0] CREDIT_FULL = N_BITS_CREDIT'(CREDIT_DEPTH);

    typedef enum logic [1:0] {IDLE, ALLOC, SETTLE} state_t;

    state_t                   state;
    logic [N_BITS_REQ-1:0]    rr_ptr;
    logic [N_BITS_REQ-1:0]    win_q;
    logic [N_BITS_VC-1:0]     vc_q;
    logic [N_BITS_CREDIT-1:0] credit_cnt [N_TOT_OF_VC];
    logic                     err_q;

    // A VC can be handed out only when it is free and its downstream buffer is completely empty.
    logic [N_TOT_OF_VC-1:0] vc_elig;
    logic [N_OF_VN-1:0]     vn_has_vc;
    logic [N_BITS_VC-1:0]   vn_first_vc [N_OF_VN];
    always_comb begin
        vc_elig   = '0;
        vn_has_vc = '0;
        for (int n = 0; n < N_OF_VN; n++) vn_first_vc[n] = '0;
        for (int v = 0; v < N_TOT_OF_VC; v++)
            vc_elig[v] = !bus.fifo_pointer_state_i[v] && (credit_cnt[v] == CREDIT_FULL);
        // The scan runs from the top of each VN downwards, so the lowest eligible index is the one left standing.
        for (int n = 0; n < N_OF_VN; n++) begin
            for (int c = N_OF_VC - 1; c >= 0; c--) begin
                if (vc_elig[n*N_OF_VC + c]) begin
                    vn_has_vc[n]   = 1'b1;
                    vn_first_vc[n] = N_BITS_VC'(n*N_OF_VC + c);
                end
            end
        end
    end

    // A requester is eligible when its VN has a usable VC. A VN index that is out of range never matches.
    logic [N_REQ-1:0]     req_elig;
    logic [N_BITS_VC-1:0] req_vc [N_REQ];
    always_comb begin
        req_elig = '0;
        for (int r = 0; r < N_REQ; r++) begin
            req_vc[r] = '0;
            for (int n = 0; n < N_OF_VN; n++) begin
                if (bus.req_i[r] && (bus.req_vn_i[r*N_BITS_VN +: N_BITS_VN] == N_BITS_VN'(n)) && vn_has_vc[n]) begin
                    req_elig[r] = 1'b1;
                    req_vc[r]   = vn_first_vc[n];
                end
            end
        end
    end

    // Round-robin search. It starts at rr_ptr, and ineligible requesters are simply passed over.
    logic                  found;
    logic [N_BITS_REQ-1:0] win_d;
    logic [N_BITS_VC-1:0]  win_vc_d;
    int                    j;
    always_comb begin
        found    = 1'b0;
        win_d    = '0;
        win_vc_d = '0;
        j        = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && req_elig[j]) begin
                found    = 1'b1;
                win_d    = N_BITS_REQ'(j);
                win_vc_d = req_vc[j];
            end
        end
    end

    // The winner is re-checked in ALLOC. Dropping the request, or the VC going busy in the meantime,
    // cancels the grant. A reset asserted in ALLOC cancels it as well.
    logic alloc_ok;
    assign alloc_ok = rst && (state == ALLOC) && bus.req_i[win_q] && !bus.fifo_pointer_state_i[vc_q];

    logic [N_REQ-1:0]                      grant_d;
    logic [N_TOT_OF_VC-1:0]                gptr_d;
    logic [N_TOT_OF_VC*N_BITS_POINTER-1:0] gbid_d;
    logic [N_BITS_VC-1:0]                  gvc_d;
    logic [N_TOT_OF_VC-1:0]                avail_d;
    logic [N_TOT_OF_VC-1:0]                flit_dec;
    always_comb begin
        grant_d = '0;
        gptr_d  = '0;
        gbid_d  = '0;
        gvc_d   = '0;
        if (alloc_ok) begin
            grant_d[win_q]                                 = 1'b1;
            gptr_d[vc_q]                                   = 1'b1;
            gbid_d[vc_q*N_BITS_POINTER +: N_BITS_POINTER]  = N_BITS_POINTER'(win_q);
            gvc_d                                          = vc_q;
        end
        avail_d  = '0;
        flit_dec = '0;
        for (int v = 0; v < N_TOT_OF_VC; v++) begin
            avail_d[v]  = (credit_cnt[v] != '0);
            flit_dec[v] = bus.flit_sent_i && (bus.flit_vc_i == N_BITS_VC'(v));
        end
    end

    assign bus.grant_o                = grant_d;
    assign bus.g_fifo_pointer_o       = gptr_d;
    assign bus.g_fifo_out_buffer_id_o = gbid_d;
    assign bus.grant_vc_o             = gvc_d;
    assign bus.credit_avail_o         = avail_d;
    assign bus.err_o                  = err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            win_q  <= '0;
            vc_q   <= '0;
            err_q  <= 1'b0;
            for (int v = 0; v < N_TOT_OF_VC; v++) credit_cnt[v] <= CREDIT_FULL;
        end else begin
            // Credits are tracked in every state. A sent flit and a returned credit in the same cycle cancel out.
            for (int v = 0; v < N_TOT_OF_VC; v++) begin
                if (flit_dec[v] && !bus.credit_signal_i[v]) begin
                    if (credit_cnt[v] == '0) err_q <= 1'b1;
                    else                     credit_cnt[v] <= credit_cnt[v] - 1'b1;
                end else if (bus.credit_signal_i[v] && !flit_dec[v]) begin
                    if (credit_cnt[v] == CREDIT_FULL) err_q <= 1'b1;
                    else                              credit_cnt[v] <= credit_cnt[v] + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (found) begin
                        win_q <= win_d;
                        vc_q  <= win_vc_d;
                        state <= ALLOC;
                    end
                end
                ALLOC: begin
                    if (alloc_ok) begin
                        rr_ptr <= (win_q == N_BITS_REQ'(N_REQ - 1)) ? '0 : win_q + 1'b1;
                        state  <= SETTLE;
                    end else begin
                        state  <= IDLE;
                    end
                end
                SETTLE:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
